fp4_butterfly_pipe: RTL and testbench
=====================================

# fp4_butterfly_pipe

Pipelined, multi-lane radix-2 butterfly for the FP4 complex datapath. It processes `LANES` independent butterflies per beat under a valid/ready handshake. Each beat selects DIT or DIF form and carries a sideband tag. The block sits between the FFT stage memory read port and its write-back. It replaces the combinational single-lane butterfly in the stage controller. Arithmetic is built from the existing `fp4_cmul` and `fp4_complex_add_sub` primitives, so results match them bit-for-bit.

## Interface
- `LANES`, default 2: number of parallel butterflies per beat (1..8).
- `TAG_W`, default 4: width of the pass-through sideband tag (≥1).
- `clk` in 1: single clock; all state is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_mode` in 1: 0 = DIT, 1 = DIF; latched with the beat.
- `in_a`, `in_b`, `in_w` in 8·LANES: per lane `{re[3:0], im[3:0]}`; lane k is bits [8k+7:8k].
- `in_tag` in TAG_W: sideband, returned unchanged with the result.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: consumer accepts the result.
- `out_x`, `out_y` out 8·LANES: butterfly outputs, same packing.
- `out_tag` out TAG_W: tag of the result beat.
- `busy` out 1: any pipeline stage holds a valid beat.

## Operation
- FP4 is E2M1, bias 1, sign in MSB. Overflow, rounding and zero handling are exactly those of the primitives.
- DIT (mode 0): P = W·B; X = A + P; Y = A − P.
- DIF (mode 1): X = A + B; Y = (A − B)·W.
- Lanes are fully independent. The mode and tag apply to all lanes of a beat.
- Three register stages, each holding a valid bit plus payload:
  - S1 registers A, B, W, mode and tag.
  - S2 registers the first operation: W·B for DIT; the sum and difference A+B, A−B for DIF. A and W are carried forward.
  - S3 registers the final X and Y and drives the `out_*` ports.
- Global advance enable `adv = !out_valid | out_ready`.
  - When `adv` = 1, every stage loads from its predecessor. Valid bits shift too.
  - When `adv` = 0, every stage holds.
- `in_ready = adv`. A beat is accepted when `in_valid & in_ready`. S1's valid bit loads `in_valid & adv`.
- Bubbles propagate and are not squeezed out. With `out_ready` held at 1, throughput is one beat per cycle.
- Payload registers may load unconditionally on `adv`. Only the valid bits require reset.
- `busy = v1 | v2 | v3`.

## Timing
- Reset, asynchronous on `rst_n` low:
  - v1, v2, v3 = 0.
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - `out_x`, `out_y` and `out_tag` are reset to 0.
- Latency: a beat accepted at edge n appears on `out_*` with `out_valid` = 1 after edge n+2. This holds when there are no stalls.
- `out_*` stay stable while `out_valid & !out_ready`.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- Output holding while consumer stalls: if `out_ready` = 0 with `out_valid` = 1, nothing is accepted, lost or duplicated. The full pipe holds 3 beats.
- Simultaneous accept and drain in one cycle is allowed. Occupancy is unchanged.
- Reset asserted mid-stream discards all in-flight beats immediately. No partial beat emerges after release.
- A mode change between consecutive beats takes effect per beat, with no drain required.

## Configuration
- `FP4_BFLY_CONJ_EN` defined:
  - Adds input `in_conj` (1 bit), latched with the beat.
  - When `in_conj` = 1, W is replaced by conj(W) (imaginary sign bit inverted) before use. This supports the inverse FFT with the same twiddle ROM.
- `FP4_BFLY_CONJ_EN` undefined: the port is absent and W is used as given.

## Test plan
- Reset: `rst_n` = 0 with random inputs → `out_valid` = 0, `busy` = 0, `in_ready` = 1, `out_x` = `out_y` = 0.
- DIT, LANES = 2, both lanes A = 8'h40, B = 8'h20, W = 8'h20, tag = 4'h5, `out_ready` = 1 → after 3 edges, both lanes X = 8'h50 and Y = 8'h20, `out_tag` = 4'h5.
- DIF, same operands → X = 8'h50, Y = 8'h20. Then A = B = 8'h20, W = 8'h20 → X = 8'h40, Y = 8'h00.
- Streaming: 16 back-to-back beats with random operands, modes and tags, `out_ready` = 1:
  - one result per cycle, in order;
  - every lane equals the composed primitive model.
- Backpressure: random `out_ready` at 50% over 200 beats:
  - no loss or duplication;
  - `out_*` stable during stalls;
  - `in_ready` = 0 exactly when `out_valid & !out_ready`.
- Reset mid-stream with 3 beats in flight → no outputs after release. The next accepted beat emerges after 3 edges with correct data. With `FP4_BFLY_CONJ_EN`, W = 8'h22 and `in_conj` = 1 gives the same result as W = 8'h2A with `in_conj` = 0.

Source files
------------

// File: rtl/fp4_butterfly_pipe.sv
// fp4_butterfly_pipe: three-stage, multi-lane radix-2 FP4 (E2M1) butterfly.
// mode 0 = DIT (X = A + W*B, Y = A - W*B); mode 1 = DIF (X = A + B, Y = (A - B)*W).
// Optional macro FP4_BFLY_CONJ_EN adds in_conj, which conjugates W per beat.
module fp4_butterfly_pipe #(
  parameter int LANES = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [8*LANES-1:0]   in_a,
  input  logic [8*LANES-1:0]   in_b,
  input  logic [8*LANES-1:0]   in_w,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef FP4_BFLY_CONJ_EN
  input  logic                 in_conj,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_x,
  output logic [8*LANES-1:0]   out_y,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int DW = 8 * LANES;

  // FP4 magnitude in half units (0, 0.5, 1, 1.5, 2, 3, 4, 6 -> 0..12), signed
  function automatic logic signed [11:0] fp4_dec(input logic [3:0] f);
    logic signed [11:0] mag;
    case (f[2:0])
      3'd0:    mag = 12'sd0;
      3'd1:    mag = 12'sd1;
      3'd2:    mag = 12'sd2;
      3'd3:    mag = 12'sd3;
      3'd4:    mag = 12'sd4;
      3'd5:    mag = 12'sd6;
      3'd6:    mag = 12'sd8;
      default: mag = 12'sd12;
    endcase
    return f[3] ? -mag : mag;
  endfunction

  // Round a value in quarter units to FP4: nearest, ties to even mantissa,
  // saturate at 6.0, exact zero is always +0.
  function automatic logic [3:0] fp4_enc(input logic signed [11:0] q);
    logic [11:0] m;
    logic [2:0]  c;
    m = q[11] ? -q : q;
    if      (m <= 12'd1)  c = 3'd0;
    else if (m <  12'd3)  c = 3'd1;
    else if (m <= 12'd5)  c = 3'd2;
    else if (m <  12'd7)  c = 3'd3;
    else if (m <= 12'd10) c = 3'd4;
    else if (m <  12'd14) c = 3'd5;
    else if (m <= 12'd20) c = 3'd6;
    else                  c = 3'd7;
    return {q[11] & (c != 3'd0), c};
  endfunction

  // Complex multiply; half*half units give quarter units directly
  function automatic logic [7:0] fp4_cmul(input logic [7:0] a, input logic [7:0] b);
    logic signed [11:0] ar, ai, br, bi, re, im;
    ar = fp4_dec(a[7:4]);
    ai = fp4_dec(a[3:0]);
    br = fp4_dec(b[7:4]);
    bi = fp4_dec(b[3:0]);
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {fp4_enc(re), fp4_enc(im)};
  endfunction

  // Complex add/subtract; half-unit sums are scaled to quarter units for rounding
  function automatic logic [7:0] fp4_complex_add_sub(input logic [7:0] a, input logic [7:0] b,
                                                     input logic sub);
    logic signed [11:0] sr, si;
    sr = sub ? fp4_dec(a[7:4]) - fp4_dec(b[7:4]) : fp4_dec(a[7:4]) + fp4_dec(b[7:4]);
    si = sub ? fp4_dec(a[3:0]) - fp4_dec(b[3:0]) : fp4_dec(a[3:0]) + fp4_dec(b[3:0]);
    return {fp4_enc(sr <<< 1), fp4_enc(si <<< 1)};
  endfunction

  logic             adv;
  logic             v1, v2, v3;
  logic [DW-1:0]    w_in;
  logic [DW-1:0]    s1_a, s1_b, s1_w;
  logic             s1_mode;
  logic [TAG_W-1:0] s1_tag;
  // s2_u holds A (DIT) or A+B (DIF); s2_p holds W*B (DIT) or A-B (DIF)
  logic [DW-1:0]    s2_u, s2_p, s2_w;
  logic             s2_mode;
  logic [TAG_W-1:0] s2_tag;
  logic [DW-1:0]    s2_u_d, s2_p_d, x_d, y_d;

  assign adv       = !v3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;
  assign busy      = v1 | v2 | v3;

  // Twiddle as used by the datapath (optionally conjugated per beat)
  always_comb begin
    w_in = in_w;
`ifdef FP4_BFLY_CONJ_EN
    for (int unsigned k = 0; k < LANES; k++) begin
      w_in[8*k+3] = in_w[8*k+3] ^ in_conj;
    end
`endif
  end

  // First operation per lane: W*B for DIT, A+B and A-B for DIF
  always_comb begin
    s2_u_d = '0;
    s2_p_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (s1_mode) begin
        s2_u_d[8*k +: 8] = fp4_complex_add_sub(s1_a[8*k +: 8], s1_b[8*k +: 8], 1'b0);
        s2_p_d[8*k +: 8] = fp4_complex_add_sub(s1_a[8*k +: 8], s1_b[8*k +: 8], 1'b1);
      end else begin
        s2_u_d[8*k +: 8] = s1_a[8*k +: 8];
        s2_p_d[8*k +: 8] = fp4_cmul(s1_w[8*k +: 8], s1_b[8*k +: 8]);
      end
    end
  end

  // Final operation per lane: A +/- P for DIT, pass sum and (A-B)*W for DIF
  always_comb begin
    x_d = '0;
    y_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (s2_mode) begin
        x_d[8*k +: 8] = s2_u[8*k +: 8];
        y_d[8*k +: 8] = fp4_cmul(s2_p[8*k +: 8], s2_w[8*k +: 8]);
      end else begin
        x_d[8*k +: 8] = fp4_complex_add_sub(s2_u[8*k +: 8], s2_p[8*k +: 8], 1'b0);
        y_d[8*k +: 8] = fp4_complex_add_sub(s2_u[8*k +: 8], s2_p[8*k +: 8], 1'b1);
      end
    end
  end

  // Pipeline registers: all stages advance together on adv, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_w    <= '0;
      s1_mode <= 1'b0;
      s1_tag  <= '0;
      s2_u    <= '0;
      s2_p    <= '0;
      s2_w    <= '0;
      s2_mode <= 1'b0;
      s2_tag  <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_tag <= '0;
    end else if (adv) begin
      v1      <= in_valid;
      v2      <= v1;
      v3      <= v2;
      s1_a    <= in_a;
      s1_b    <= in_b;
      s1_w    <= w_in;
      s1_mode <= in_mode;
      s1_tag  <= in_tag;
      s2_u    <= s2_u_d;
      s2_p    <= s2_p_d;
      s2_w    <= s1_w;
      s2_mode <= s1_mode;
      s2_tag  <= s1_tag;
      out_x   <= x_d;
      out_y   <= y_d;
      out_tag <= s2_tag;
    end
  end

endmodule

// File: tb/tb_fp4_butterfly_pipe.sv
// Self-checking bench for fp4_butterfly_pipe (LANES=2, TAG_W=4).
// Reference model works on real values: decode FP4, do exact complex math,
// round to the nearest representable FP4 (ties to even mantissa, saturating).
module tb_fp4_butterfly_pipe;

  localparam int LANES = 2;
  localparam int TAG_W = 4;
  localparam int DW    = 8 * LANES;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_mode, in_conj;
  logic [DW-1:0]    in_a, in_b, in_w;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, busy;
  logic [DW-1:0]    out_x, out_y;
  logic [TAG_W-1:0] out_tag;

  fp4_butterfly_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag),
`ifdef FP4_BFLY_CONJ_EN
    .in_conj(in_conj),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  real mags[8] = '{0.0, 0.5, 1.0, 1.5, 2.0, 3.0, 4.0, 6.0};

  function automatic real dec(input logic [3:0] f);
    real m;
    m = mags[f[2:0]];
    return f[3] ? -m : m;
  endfunction

  function automatic logic [3:0] enc(input real v);
    real av, d, bd;
    int bc;
    av = (v < 0.0) ? -v : v;
    bd = 1.0e9;
    bc = 0;
    for (int c = 0; c < 8; c++) begin
      d = av - mags[c];
      if (d < 0.0) d = -d;
      if (d < bd || (d == bd && (c % 2) == 0)) begin
        bd = d;
        bc = c;
      end
    end
    return {(v < 0.0 && bc != 0), 3'(bc)};
  endfunction

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    real ar, ai, br, bi;
    ar = dec(a[7:4]); ai = dec(a[3:0]); br = dec(b[7:4]); bi = dec(b[3:0]);
    return {enc(ar * br - ai * bi), enc(ar * bi + ai * br)};
  endfunction

  function automatic logic [7:0] m_add(input logic [7:0] a, input logic [7:0] b, input bit neg);
    real s;
    s = neg ? -1.0 : 1.0;
    return {enc(dec(a[7:4]) + s * dec(b[7:4])), enc(dec(a[3:0]) + s * dec(b[3:0]))};
  endfunction

  function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] w, input logic mode, input logic cj);
    logic [DW-1:0] x, y;
    logic [7:0] al, bl, wl, p, d;
    x = '0; y = '0;
    for (int k = 0; k < LANES; k++) begin
      al = a[8*k +: 8]; bl = b[8*k +: 8]; wl = w[8*k +: 8];
      if (cj) wl[3] = ~wl[3];
      if (!mode) begin
        p = m_mul(wl, bl);
        x[8*k +: 8] = m_add(al, p, 1'b0);
        y[8*k +: 8] = m_add(al, p, 1'b1);
      end else begin
        d = m_add(al, bl, 1'b1);
        x[8*k +: 8] = m_add(al, bl, 1'b0);
        y[8*k +: 8] = m_mul(d, wl);
      end
    end
    return {x, y};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  typedef struct {
    logic [DW-1:0]    x;
    logic [DW-1:0]    y;
    logic [TAG_W-1:0] tag;
    int               t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  bit   lat_chk = 0;
  bit   prev_stall = 0;
  logic [DW-1:0]    prev_x, prev_y;
  logic [TAG_W-1:0] prev_tag;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
      chk(!out_valid && !busy && in_ready && out_x == '0 && out_y == '0 && out_tag == '0,
          "reset_outputs", {out_valid, busy, in_ready, out_tag, out_x, out_y},
          {1'b0, 1'b0, 1'b1, 4'h0, 32'h0});
    end else begin
      cyc++;
      chk(in_ready == !(out_valid && !out_ready), "in_ready_rule", 64'(in_ready),
          64'(!(out_valid && !out_ready)));
      chk(busy == (q.size() != 0), "busy", 64'(busy), 64'(q.size() != 0));
      if (prev_stall)
        chk(out_x == prev_x && out_y == prev_y && out_tag == prev_tag && out_valid,
            "stall_stable", {out_tag, out_x, out_y}, {prev_tag, prev_x, prev_y});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_output", {out_tag, out_x, out_y}, 64'h0);
        end else begin
          e = q.pop_front();
          chk(out_x == e.x, "out_x", 64'(out_x), 64'(e.x));
          chk(out_y == e.y, "out_y", 64'(out_y), 64'(e.y));
          chk(out_tag == e.tag, "out_tag", 64'(out_tag), 64'(e.tag));
          if (lat_chk) chk(cyc - e.t == 3, "latency", 64'(cyc - e.t), 64'd3);
        end
      end
      if (in_valid && in_ready) begin
        {e.x, e.y} = model(in_a, in_b, in_w, in_mode, in_conj);
        e.tag = in_tag;
        e.t   = cyc;
        q.push_back(e);
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_x = out_x; prev_y = out_y; prev_tag = out_tag;
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_inputs();
    in_a   = DW'($urandom);
    in_b   = DW'($urandom);
    in_w   = DW'($urandom);
    in_mode = 1'($urandom_range(0, 1));
    in_tag = TAG_W'($urandom);
  endtask

  // One directed beat on an idle pipe, result checked against literals
  task automatic run_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] w,
                         input logic m, input logic [TAG_W-1:0] t,
                         input logic [DW-1:0] ex, input logic [DW-1:0] ey, input string nm);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_w = w; in_tag = t; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(out_valid && n == 2, {nm, "_latency"}, 64'(n), 64'd2);
    chk(out_x == ex, {nm, "_x"}, 64'(out_x), 64'(ex));
    chk(out_y == ey, {nm, "_y"}, 64'(out_y), 64'(ey));
    chk(out_tag == t, {nm, "_tag"}, 64'(out_tag), 64'(t));
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int target, guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_conj = 1'b0;
    rand_inputs();
    repeat (2) begin
      @(posedge clk); #1;
      rand_inputs();
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
    end
    chk(!out_valid && !busy && in_ready && out_x == '0 && out_y == '0, "reset_state",
        {out_valid, busy, in_ready, out_x, out_y}, {1'b0, 1'b0, 1'b1, 32'h0});
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed: hand-computed expectations
    lat_chk = 1;
    run_one(16'h4040, 16'h2020, 16'h2020, 1'b0, 4'h5, 16'h5050, 16'h2020, "dit_basic");
    run_one(16'h4040, 16'h2020, 16'h2020, 1'b1, 4'h9, 16'h5050, 16'h2020, "dif_basic");
    run_one(16'h2020, 16'h2020, 16'h2020, 1'b1, 4'h3, 16'h4040, 16'h0000, "dif_zero");
    // 3 + 2 = 5 is a tie between 4 and 6 and must round to 4; 6 + 6 saturates to 6
    run_one(16'h5070, 16'h2020, 16'h4070, 1'b0, 4'hC, 16'h6070, 16'h2000, "dit_round_sat");

    // Streaming: 16 back-to-back beats
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      rand_inputs();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk(q.size() == 0, "stream_drained", 64'(q.size()), 64'd0);
    lat_chk = 0;

    // Backpressure: random out_ready at 50% until 200 beats accepted
    target = acc_cnt + 200;
    guard = 0;
    while (acc_cnt < target && guard < 4000) begin
      @(posedge clk); #1;
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      guard++;
    end
    chk(guard < 4000, "bp_timeout", 64'(guard), 64'd4000);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk(q.size() == 0, "bp_drained", 64'(q.size()), 64'd0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rand_inputs();
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk(!out_valid && !busy, "midreset_flush", {out_valid, busy}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk(!out_valid, "no_output_after_reset", 64'(out_valid), 64'h0);
    end
    lat_chk = 1;
    run_one(16'h2020, 16'h2020, 16'h2020, 1'b1, 4'hA, 16'h4040, 16'h0000, "post_reset");

`ifdef FP4_BFLY_CONJ_EN
    // conj(1+i) = 1-i: X = 2 + (1-i) = 3-i, Y = 2 - (1-i) = 1+i
    in_conj = 1'b1;
    run_one(16'h4040, 16'h2020, 16'h2222, 1'b0, 4'h6, 16'h5A5A, 16'h2222, "conj");
    in_conj = 1'b0;
    run_one(16'h4040, 16'h2020, 16'h2A2A, 1'b0, 4'h7, 16'h5A5A, 16'h2222, "conj_ref");
`endif
    lat_chk = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
